// File: rtl/msrh_br_upd_arb.sv
// Branch-update arbiter: per-pipe FIFOs, round-robin grant onto one registered update port.
// Define MSRH_BR_UPD_ARB_PERF_EN to build the saturating conflict counter.
module msrh_br_upd_arb #(
  parameter int unsigned REQ_NUM    = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CMT_ID_W   = 6,
  parameter int unsigned GRP_ID_W   = 4,
  parameter int unsigned VADDR_W    = 39,
  parameter int unsigned BR_MASK_W  = 8,
  localparam int unsigned PW        = CMT_ID_W + GRP_ID_W + 4 + VADDR_W,
  localparam int unsigned TAG_W     = $clog2(BR_MASK_W)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [REQ_NUM-1:0]           i_req_valid,
  input  logic [REQ_NUM*PW-1:0]        i_req_payload,
  input  logic [REQ_NUM*BR_MASK_W-1:0] i_req_br_mask,
  output logic [REQ_NUM-1:0]           o_req_ready,
  input  logic                         i_flush,
  input  logic                         i_kill_valid,
  input  logic [TAG_W-1:0]             i_kill_brtag,
  input  logic                         i_resolve_valid,
  input  logic [TAG_W-1:0]             i_resolve_brtag,
  output logic                         o_upd_valid,
  output logic [PW-1:0]                o_upd_payload,
  output logic [15:0]                  o_perf_conflict_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RR_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [REQ_NUM-1:0][FIFO_DEPTH-1:0][PW-1:0]        pld_q, pld_d;
  logic [REQ_NUM-1:0][FIFO_DEPTH-1:0][BR_MASK_W-1:0] mask_q, mask_d;
  logic [REQ_NUM-1:0][FIFO_DEPTH-1:0]                vld_q, vld_d;
  logic [REQ_NUM-1:0][PTR_W-1:0]                     rptr_q, rptr_d;
  logic [REQ_NUM-1:0][PTR_W-1:0]                     wptr_q, wptr_d;
  logic [REQ_NUM-1:0][CNT_W-1:0]                     cnt_q, cnt_d;
  logic [RR_W-1:0]                                   rr_q, rr_d;
  logic                                              upd_valid_q, upd_valid_d;
  logic [PW-1:0]                                     upd_pld_q, upd_pld_d;

  logic [REQ_NUM-1:0]         head_live, push, pop;
  logic [REQ_NUM-1:0][PW-1:0] head_pld;
  logic [BR_MASK_W-1:0]       kill_bit, resolve_bit;
  logic                       found;
  logic [RR_W-1:0]            win;

  assign kill_bit    = i_kill_valid ? (BR_MASK_W'(1) << i_kill_brtag) : '0;
  assign resolve_bit = i_resolve_valid ? (BR_MASK_W'(1) << i_resolve_brtag) : '0;

  // A head being killed this cycle is already treated as dead so it cannot win.
  always_comb begin
    for (int i = 0; i < REQ_NUM; i++) begin
      o_req_ready[i] = (cnt_q[i] != CNT_W'(FIFO_DEPTH));
      head_pld[i]    = pld_q[i][rptr_q[i]];
      head_live[i]   = (cnt_q[i] != '0) && vld_q[i][rptr_q[i]] &&
                       ((mask_q[i][rptr_q[i]] & kill_bit) == '0);
    end
  end

  always_comb begin
    int unsigned     idx;
    logic [RR_W-1:0] cand;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      idx  = (int'(rr_q) + k) % REQ_NUM;
      cand = RR_W'(idx);
      if (!found && head_live[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Dead heads are reclaimed every cycle alongside whatever grant happens elsewhere.
  always_comb begin
    pld_d  = pld_q;
    mask_d = mask_q;
    vld_d  = vld_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    push   = '0;
    pop    = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        if ((mask_q[i][e] & kill_bit) != '0) vld_d[i][e] = 1'b0;
        mask_d[i][e] = mask_q[i][e] & ~resolve_bit;
      end
      pop[i]  = (cnt_q[i] != '0) && (!head_live[i] || (found && (win == RR_W'(i))));
      push[i] = i_req_valid[i] && o_req_ready[i] &&
                ((i_req_br_mask[i*BR_MASK_W +: BR_MASK_W] & kill_bit) == '0);
      if (pop[i]) begin
        vld_d[i][rptr_q[i]] = 1'b0;
        rptr_d[i]           = rptr_q[i] + 1'b1;
      end
      if (push[i]) begin
        pld_d[i][wptr_q[i]]  = i_req_payload[i*PW +: PW];
        mask_d[i][wptr_q[i]] = i_req_br_mask[i*BR_MASK_W +: BR_MASK_W] & ~resolve_bit;
        vld_d[i][wptr_q[i]]  = 1'b1;
        wptr_d[i]            = wptr_q[i] + 1'b1;
      end
      cnt_d[i] = cnt_q[i] - CNT_W'(pop[i]) + CNT_W'(push[i]);
    end
    if (i_flush) begin
      vld_d  = '0;
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_comb begin
    upd_valid_d = found && !i_flush;
    upd_pld_d   = upd_pld_q;
    rr_d        = rr_q;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (upd_valid_d && (win == RR_W'(i))) upd_pld_d = head_pld[i];
    end
    if (upd_valid_d) rr_d = (win == RR_W'(REQ_NUM - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pld_q       <= '0;
      mask_q      <= '0;
      vld_q       <= '0;
      rptr_q      <= '0;
      wptr_q      <= '0;
      cnt_q       <= '0;
      rr_q        <= '0;
      upd_valid_q <= 1'b0;
      upd_pld_q   <= '0;
    end else begin
      pld_q       <= pld_d;
      mask_q      <= mask_d;
      vld_q       <= vld_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      upd_valid_q <= upd_valid_d;
      upd_pld_q   <= upd_pld_d;
    end
  end

  assign o_upd_valid   = upd_valid_q;
  assign o_upd_payload = upd_pld_q;

`ifdef MSRH_BR_UPD_ARB_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (($countones(head_live) >= 2) && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign o_perf_conflict_cnt = perf_q;
`else
  assign o_perf_conflict_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_msrh_br_upd_arb.sv
// Bench for msrh_br_upd_arb: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_msrh_br_upd_arb;
  localparam int N   = 2;
  localparam int D   = 4;
  localparam int CW  = 6;
  localparam int GW  = 4;
  localparam int VW  = 39;
  localparam int BMW = 8;
  localparam int PW  = CW + GW + 4 + VW;
  localparam int TW  = $clog2(BMW);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*PW-1:0]  req_payload;
  logic [N*BMW-1:0] req_mask;
  logic [N-1:0]   req_ready;
  logic           flush, kill_v, res_v;
  logic [TW-1:0]  kill_tag, res_tag;
  logic           upd_valid;
  logic [PW-1:0]  upd_payload;
  logic [15:0]    perf;

  always #5 clk = ~clk;

  msrh_br_upd_arb #(
    .REQ_NUM(N), .FIFO_DEPTH(D), .CMT_ID_W(CW), .GRP_ID_W(GW), .VADDR_W(VW), .BR_MASK_W(BMW)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .i_req_payload(req_payload),
    .i_req_br_mask(req_mask), .o_req_ready(req_ready), .i_flush(flush),
    .i_kill_valid(kill_v), .i_kill_brtag(kill_tag), .i_resolve_valid(res_v),
    .i_resolve_brtag(res_tag), .o_upd_valid(upd_valid), .o_upd_payload(upd_payload),
    .o_perf_conflict_cnt(perf)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk(input int cmt, input logic [GW-1:0] grp,
                                       input logic [3:0] fl, input logic [VW-1:0] va);
    return {va, fl, grp, CW'(cmt)};
  endfunction

  task automatic set_req(input int i, input logic [PW-1:0] p, input logic [BMW-1:0] m);
    req_payload[i*PW +: PW] = p;
    req_mask[i*BMW +: BMW]  = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = '0;
    flush     = 1'b0;
    kill_v    = 1'b0;
    res_v     = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Reference model: one queue per requester, entries keep a live flag until reclaimed.
  typedef struct packed { logic v; logic [BMW-1:0] m; logic [PW-1:0] p; } ent_t;
  ent_t          mq [N][$];
  bit            exp_v;
  logic [PW-1:0] exp_p;
  int            rr_m;
  int            mperf;

  task automatic model_step();
    bit            live [N];
    bit            rdy  [N];
    int            nlive;
    int            win;
    int            idx;
    logic [PW-1:0] hp;
    logic [BMW-1:0] im;
    ent_t          e;
    nlive = 0;
    win   = -1;
    hp    = '0;
    for (int i = 0; i < N; i++) begin
      live[i] = (mq[i].size() > 0) && mq[i][0].v && !(kill_v && mq[i][0].m[kill_tag]);
      if (live[i]) nlive++;
    end
    if (nlive >= 2 && mperf < 65535) mperf++;
    if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      exp_v = 1'b0;
      return;
    end
    for (int k = 0; k < N; k++) begin
      idx = (rr_m + k) % N;
      if (win < 0 && live[idx]) win = idx;
    end
    if (win >= 0) hp = mq[win][0].p;
    for (int i = 0; i < N; i++) begin
      rdy[i] = (mq[i].size() != D);
      for (int j = 0; j < mq[i].size(); j++) begin
        e = mq[i][j];
        if (kill_v && e.m[kill_tag]) e.v = 1'b0;
        if (res_v) e.m[res_tag] = 1'b0;
        mq[i][j] = e;
      end
      if (mq[i].size() > 0 && (!live[i] || win == i)) void'(mq[i].pop_front());
      im = req_mask[i*BMW +: BMW];
      if (req_valid[i] && rdy[i] && !(kill_v && im[kill_tag])) begin
        if (res_v) im[res_tag] = 1'b0;
        mq[i].push_back({1'b1, im, req_payload[i*PW +: PW]});
      end
    end
    exp_v = (win >= 0);
    if (win >= 0) begin
      exp_p = hp;
      rr_m  = (win + 1) % N;
    end
  endtask

  initial begin
    exp_v = 1'b0; exp_p = '0; rr_m = 0; mperf = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) mq[i].delete();
        exp_v = 1'b0; exp_p = '0; rr_m = 0; mperf = 0;
      end else begin
        model_step();
      end
    end
  end

  logic [PW-1:0] obs_p [$];
  int            obs_c [$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("upd_valid", 64'(upd_valid), 64'(exp_v));
        if (exp_v) chk("upd_payload", 64'(upd_payload), 64'(exp_p));
        for (int i = 0; i < N; i++)
          chk("req_ready", 64'(req_ready[i]), 64'(mq[i].size() != D));
`ifdef MSRH_BR_UPD_ARB_PERF_EN
        chk("perf_cnt", 64'(perf), 64'(mperf));
`else
        chk("perf_cnt", 64'(perf), 64'(0));
`endif
        if (upd_valid) begin
          obs_p.push_back(upd_payload);
          obs_c.push_back(cyc);
        end
      end
    end
  end

  initial begin
    int            c0;
    int            id [N];
    logic [N-1:0]  acc;
    int            nacc;
    int            exp1;
    bit            saw_low;
    logic [63:0]   r;
    logic [BMW-1:0] m;
    req_valid = '0; req_payload = '0; req_mask = '0;
    flush = 1'b0; kill_v = 1'b0; res_v = 1'b0; kill_tag = '0; res_tag = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(upd_valid), 64'(0));
    chk("rst_payload", 64'(upd_payload), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(2'b11));
    chk("rst_perf", 64'(perf), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Single packet: out two cycles later with identical payload
    obs_p.delete(); obs_c.delete();
    set_req(0, mk(5, 4'b0010, 4'b0000, 39'h12345), '0);
    req_valid = 2'b01;
    c0 = cyc;
    tick();
    drain(4);
    chk("t1_count", 64'(obs_p.size()), 64'(1));
    if (obs_p.size() == 1) begin
      chk("t1_payload", 64'(obs_p[0]), 64'(mk(5, 4'b0010, 4'b0000, 39'h12345)));
      chk("t1_latency", 64'(obs_c[0] - c0), 64'(2));
    end

    // rr_ptr now points at requester 1, so it wins a simultaneous offer
    obs_p.delete(); obs_c.delete();
    set_req(0, mk(1, 4'h1, 4'h0, 39'h0), '0);
    set_req(1, mk(2, 4'h2, 4'h0, 39'h0), '0);
    req_valid = 2'b11;
    tick();
    drain(4);
    chk("t1b_count", 64'(obs_p.size()), 64'(2));
    if (obs_p.size() == 2) chk("t1b_first", 64'(obs_p[0][CW-1:0]), 64'(2));

    // Reset mid-operation clears outputs immediately
    set_req(0, mk(7, 4'h1, 4'h0, 39'h7), '0);
    set_req(1, mk(8, 4'h1, 4'h0, 39'h8), '0);
    req_valid = 2'b11;
    tick();
    req_valid = 2'b11;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(upd_valid), 64'(0));
    chk("midrst_payload", 64'(upd_payload), 64'(0));
    chk("midrst_ready", 64'(req_ready), 64'(2'b11));
    @(posedge clk);
    #1 rst = 1'b0;

    // Simultaneous streams alternate 0,1,0,1,0,1 on consecutive cycles
    obs_p.delete(); obs_c.delete();
    for (int k = 0; k < 3; k++) begin
      set_req(0, mk(10 + k, 4'h1, 4'h0, 39'h100), '0);
      set_req(1, mk(20 + k, 4'h2, 4'h0, 39'h200), '0);
      req_valid = 2'b11;
      tick();
    end
    drain(8);
    chk("t2_count", 64'(obs_p.size()), 64'(6));
    if (obs_p.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("t2_order", 64'(obs_p[k][CW-1:0]), 64'((k % 2 == 0) ? 10 + k / 2 : 20 + k / 2));
        chk("t2_consecutive", 64'(obs_c[k] - obs_c[0]), 64'(k));
      end
    end
`ifdef MSRH_BR_UPD_ARB_PERF_EN
    chk("t2_perf", 64'(perf), 64'(5));
`else
    chk("t2_perf", 64'(perf), 64'(0));
`endif

    // Continuous offers on both: backpressure, nothing lost or duplicated
    obs_p.delete(); obs_c.delete();
    id[0] = 0; id[1] = 32; nacc = 0; saw_low = 1'b0;
    for (int c = 0; c < 14; c++) begin
      set_req(0, mk(id[0], 4'h1, 4'h0, 39'h300), '0);
      set_req(1, mk(id[1], 4'h2, 4'h0, 39'h400), '0);
      req_valid = 2'b11;
      acc = req_ready;
      if (!req_ready[1]) saw_low = 1'b1;
      tick();
      for (int i = 0; i < N; i++) if (acc[i]) begin id[i]++; nacc++; end
    end
    drain(12);
    chk("t3_ready1_low", 64'(saw_low), 64'(1));
    chk("t3_count", 64'(obs_p.size()), 64'(nacc));
    exp1 = 32;
    for (int k = 0; k < obs_p.size(); k++) begin
      if (obs_p[k][CW-1:0] >= 32) begin
        chk("t3_req1_seq", 64'(obs_p[k][CW-1:0]), 64'(exp1));
        exp1++;
      end
    end

    // Kill tag 3: buffered head and same-cycle incoming packet both dropped
    obs_p.delete(); obs_c.delete();
    set_req(0, mk(40, 4'h1, 4'h0, 39'h1), 8'h08);
    req_valid = 2'b01;
    tick();
    set_req(0, mk(41, 4'h1, 4'h0, 39'h2), 8'h08);
    set_req(1, mk(42, 4'h2, 4'h0, 39'h3), 8'h00);
    req_valid = 2'b11;
    kill_v = 1'b1; kill_tag = 3'd3;
    tick();
    drain(5);
    chk("t4_count", 64'(obs_p.size()), 64'(1));
    if (obs_p.size() == 1) chk("t4_survivor", 64'(obs_p[0][CW-1:0]), 64'(42));

    // Resolve tag 2 the cycle before kill tag 2: packet survives
    obs_p.delete(); obs_c.delete();
    set_req(0, mk(43, 4'h4, 4'h3, 39'h44), 8'h04);
    req_valid = 2'b01;
    res_v = 1'b1; res_tag = 3'd2;
    tick();
    kill_v = 1'b1; kill_tag = 3'd2;
    tick();
    drain(4);
    chk("t5_count", 64'(obs_p.size()), 64'(1));
    if (obs_p.size() == 1) chk("t5_payload", 64'(obs_p[0]), 64'(mk(43, 4'h4, 4'h3, 39'h44)));

    // Flush with three entries queued and a new request in the same cycle
    for (int k = 0; k < 2; k++) begin
      set_req(0, mk(50 + k, 4'h1, 4'h0, 39'h5), '0);
      set_req(1, mk(52 + k, 4'h2, 4'h0, 39'h6), '0);
      req_valid = 2'b11;
      tick();
    end
    set_req(0, mk(55, 4'h1, 4'h0, 39'h7), '0);
    req_valid = 2'b01;
    flush = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_valid_after_flush", 64'(upd_valid), 64'(0));
    chk("t6_ready_after_flush", 64'(req_ready), 64'(2'b11));
    obs_p.delete(); obs_c.delete();
    set_req(0, mk(56, 4'h8, 4'h0, 39'h8), '0);
    req_valid = 2'b01;
    c0 = cyc;
    tick();
    drain(4);
    chk("t6_count", 64'(obs_p.size()), 64'(1));
    if (obs_p.size() == 1) begin
      chk("t6_payload", 64'(obs_p[0][CW-1:0]), 64'(56));
      chk("t6_latency", 64'(obs_c[0] - c0), 64'(2));
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        r = {$urandom(), $urandom()};
        m = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) :
            8'($urandom() & $urandom() & $urandom());
        set_req(i, r[PW-1:0], m);
        req_valid[i] = ($urandom_range(0, 99) < 65);
      end
      kill_v   = ($urandom_range(0, 99) < 8);
      kill_tag = TW'($urandom_range(0, 7));
      res_v    = ($urandom_range(0, 99) < 12);
      res_tag  = TW'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 199) == 0);
      tick();
    end
    drain(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
